// File: rtl/bwt_pkg.sv
// Shared types and constants for the BWT prefix-doubling control path.
package bwt_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic RANK_SRC_CHAR   = 1'b0;
  localparam logic RANK_SRC_BUCKET = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD      = 4'd1,
    ST_SORT_REQ  = 4'd2,
    ST_SORT_WAIT = 4'd3,
    ST_BB_REQ    = 4'd4,
    ST_BB_WAIT   = 4'd5,
    ST_CHECK     = 4'd6,
    ST_UPDATE    = 4'd7,
    ST_FIN       = 4'd8
  } ctrl_state_t;

  // Doubling offset that sticks at its top bit instead of wrapping to zero.
  function automatic logic [DATA_W-1:0] k_double_sat(input logic [DATA_W-1:0] k_cur);
    return k_cur[DATA_W-1] ? k_cur : (k_cur << 1);
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector: pulses while d is high and was low last cycle.
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/bwt_doubling_ctrl.sv
// Prefix-doubling round sequencer: drives the pair sorter and bucket builder
// once per round until buckets are unique or the round budget is spent.
module bwt_doubling_ctrl
  import bwt_pkg::*;
#(
  parameter int unsigned STRING_LEN = 8,
  parameter int unsigned MAX_ITER   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] k,
  output logic [DATA_W-1:0] iter,
  output logic              rank_load,
  output logic              rank_src_sel,
  output logic              sort_start,
  input  logic              sort_done,
  output logic              bb_start,
  input  logic              bb_done,
  input  logic [DATA_W-1:0] bb_max_bucket
);

  ctrl_state_t       state, state_n;
  logic [DATA_W-1:0] k_n, iter_n, max_q, max_n;
  logic              err_n;
  logic              bb_rise_c;

  // A builder done level left over from the previous round must not count.
  edge_detect_rise u_bb_done_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (bb_done),
    .rise_c (bb_rise_c)
  );

  always_comb begin
    state_n = state;
    k_n     = k;
    iter_n  = iter;
    err_n   = err;
    max_n   = max_q;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_LOAD;
          k_n     = DATA_W'(1);
          iter_n  = '0;
          err_n   = 1'b0;
        end
      end
      ST_LOAD:      state_n = ST_SORT_REQ;
      ST_SORT_REQ:  state_n = ST_SORT_WAIT;
      ST_SORT_WAIT: if (sort_done) state_n = ST_BB_REQ;
      ST_BB_REQ:    state_n = ST_BB_WAIT;
      ST_BB_WAIT: begin
        if (bb_rise_c) begin
          max_n   = bb_max_bucket;
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        iter_n = iter + DATA_W'(1);
        if (32'(max_q) >= STRING_LEN) begin
          state_n = ST_FIN;
        end else if (32'(iter_n) == MAX_ITER) begin
          err_n   = 1'b1;
          state_n = ST_FIN;
        end else begin
          state_n = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        k_n     = k_double_sat(k);
        state_n = ST_SORT_REQ;
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output comes off a flop
  // yet lines up with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      k            <= DATA_W'(1);
      iter         <= '0;
      max_q        <= '0;
      rank_load    <= 1'b0;
      rank_src_sel <= RANK_SRC_CHAR;
      sort_start   <= 1'b0;
      bb_start     <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != ST_IDLE);
      done       <= (state_n == ST_FIN);
      rank_load  <= (state_n == ST_LOAD) || (state_n == ST_UPDATE);
      sort_start <= (state_n == ST_SORT_REQ);
      bb_start   <= (state_n == ST_BB_REQ);
      if (state_n == ST_LOAD)        rank_src_sel <= RANK_SRC_CHAR;
      else if (state_n == ST_UPDATE) rank_src_sel <= RANK_SRC_BUCKET;
      err   <= err_n;
      k     <= k_n;
      iter  <= iter_n;
      max_q <= max_n;
    end
  end

endmodule

// File: tb/tb_bwt_doubling_ctrl.sv
// Self-checking bench for bwt_doubling_ctrl with behavioural sorter and
// bucket-builder models and a round-level reference of the job outcome.
module tb_bwt_doubling_ctrl;

  localparam int unsigned STRING_LEN = 8;
  localparam int unsigned MAX_ITER   = 4;

  logic       clk = 1'b0;
  logic       rst, start, sort_done, bb_done;
  logic [7:0] bb_max_bucket;
  logic       busy, done, err, rank_load, rank_src_sel, sort_start, bb_start;
  logic [7:0] k, iter;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int              sort_lat;
    int              hold;
    int              low;
    logic [3:0][7:0] rmax;
    int              exp_iter;
    int              exp_err;
    int              exp_klast;
  } job_t;

  bwt_doubling_ctrl #(.STRING_LEN(STRING_LEN), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .k(k), .iter(iter), .rank_load(rank_load), .rank_src_sel(rank_src_sel),
    .sort_start(sort_start), .sort_done(sort_done), .bb_start(bb_start),
    .bb_done(bb_done), .bb_max_bucket(bb_max_bucket)
  );

  always #5 clk = ~clk;

  function automatic job_t mk_job(int lat, int hold, int low, int m0, int m1, int m2,
                                  int m3, int ei, int ee, int ek);
    job_t j;
    j.sort_lat  = lat;
    j.hold      = hold;
    j.low       = low;
    j.rmax[0]   = 8'(m0);
    j.rmax[1]   = 8'(m1);
    j.rmax[2]   = 8'(m2);
    j.rmax[3]   = 8'(m3);
    j.exp_iter  = ei;
    j.exp_err   = ee;
    j.exp_klast = ek;
    return j;
  endfunction

  // Reference: the job stops at the first round whose max reaches STRING_LEN,
  // otherwise after MAX_ITER rounds with an error; round r uses k = 2**r.
  function automatic int model_iter(job_t j);
    for (int r = 0; r < int'(MAX_ITER); r++)
      if (int'(j.rmax[r]) >= int'(STRING_LEN)) return r + 1;
    return int'(MAX_ITER);
  endfunction

  function automatic int model_err(job_t j);
    for (int r = 0; r < int'(MAX_ITER); r++)
      if (int'(j.rmax[r]) >= int'(STRING_LEN)) return 0;
    return 1;
  endfunction

  function automatic int model_k(int r);
    return (r >= 7) ? 128 : (1 << r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_k", int'(k), 1);
    check("rst_iter", int'(iter), 0);
    check("rst_rank_load", int'(rank_load), 0);
    check("rst_rank_src_sel", int'(rank_src_sel), 0);
    check("rst_sort_start", int'(sort_start), 0);
    check("rst_bb_start", int'(bb_start), 0);
  endtask

  // Runs one job against the sorter/builder models. inj pokes start during
  // SORT_WAIT and FIN; do_rst fires an async reset in the first BB_WAIT.
  task automatic run_job(input job_t j, input int e_iter, input int e_err, input int e_k,
                         input bit inj, input bit do_rst);
    int sort_cnt = 0, bb_t = -1, rnd = 0, n_sort = 0, n_load = 0, n_bb = 0;
    int first_sort = -1, last_sort = -1, cur = 0;
    bit finished = 1'b0, aborted = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    for (int c = 0; c < 300 && !finished && !aborted; c++) begin
      start     = 1'b0;
      sort_done = 1'b0;
      if (rank_load) begin
        n_load++;
        check("rank_src_sel", int'(rank_src_sel), (n_load == 1) ? 0 : 1);
      end
      if (sort_cnt > 0) begin
        sort_cnt--;
        sort_done = (sort_cnt == 0);
      end
      if (sort_start) begin
        check("k_at_sort", int'(k), model_k(n_sort));
        check("iter_at_sort", int'(iter), n_sort);
        if (last_sort >= 0)
          check("round_period", c - last_sort, j.sort_lat + j.hold + j.low + 4);
        if (first_sort < 0) first_sort = c;
        last_sort = c;
        n_sort++;
        sort_cnt = j.sort_lat;
      end
      if (inj && first_sort >= 0 && c == first_sort + 1) start = 1'b1;
      if (bb_start) begin
        n_bb++;
        bb_t = 0;
        cur  = (rnd < 4) ? int'(j.rmax[rnd]) : 0;
        rnd++;
        bb_max_bucket = 8'd200;
      end else if (bb_t >= 0) begin
        bb_t++;
      end
      if (bb_t >= 0) begin
        if (bb_t >= j.hold + j.low) begin
          bb_done       = 1'b1;
          bb_max_bucket = 8'(cur);
        end else if (bb_t >= j.hold) begin
          bb_done = 1'b0;
        end
      end
      if (do_rst && n_bb == 1 && bb_t == 1) begin
        #2 rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst       = 1'b0;
        bb_done   = 1'b0;
        sort_done = 1'b0;
        aborted   = 1'b1;
      end
      if (done) begin
        check("done_iter", int'(iter), e_iter);
        check("done_err", int'(err), e_err);
        check("done_k", int'(k), e_k);
        check("done_timing", c - last_sort, j.sort_lat + j.hold + j.low + 3);
        check("sort_pulses", n_sort, e_iter);
        check("load_pulses", n_load, e_iter);
        check("bb_pulses", n_bb, e_iter);
        check("src_at_done", int'(rank_src_sel), (e_iter > 1) ? 1 : 0);
        if (inj) start = 1'b1;
        finished = 1'b1;
      end
      if (!aborted) tick();
    end
    start = 1'b0;
    if (!finished && !aborted) check("job_timeout", 0, 1);
    if (finished) begin
      check("done_one_cycle", int'(done), 0);
      check("busy_dropped", int'(busy), 0);
      repeat (3) tick();
      check("no_second_job", int'(busy), 0);
      check("iter_holds", int'(iter), e_iter);
      check("err_holds", int'(err), e_err);
    end
  endtask

  initial begin
    job_t tbl[7];
    job_t rj;
    rst           = 1'b1;
    start         = 1'b0;
    sort_done     = 1'b0;
    bb_done       = 1'b0;
    bb_max_bucket = 8'd0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_busy", int'(busy), 0);

    tbl[0] = mk_job(3, 0, 2, 3, 6, 8, 0, 3, 0, 4);  // converges in round 3
    tbl[1] = mk_job(2, 0, 1, 5, 5, 5, 5, 4, 1, 8);  // budget exhausted
    tbl[2] = mk_job(2, 2, 2, 3, 8, 0, 0, 2, 0, 2);  // stale-high done carried over
    tbl[3] = mk_job(1, 0, 1, 8, 0, 0, 0, 1, 0, 1);  // single round
    tbl[4] = mk_job(4, 1, 3, 1, 2, 3, 8, 4, 0, 8);  // success on last allowed round
    tbl[5] = mk_job(1, 0, 1, 7, 7, 7, 7, 4, 1, 8);  // one short of unique every round
    tbl[6] = mk_job(2, 3, 1, 0, 9, 0, 0, 2, 0, 2);  // max above STRING_LEN
    foreach (tbl[i])
      run_job(tbl[i], tbl[i].exp_iter, tbl[i].exp_err, tbl[i].exp_klast, 1'b0, 1'b0);

    // Start pokes during SORT_WAIT and FIN are dropped.
    run_job(tbl[0], 3, 0, 4, 1'b1, 1'b0);

    // Async reset while idle with err held high clears it at once.
    run_job(tbl[1], 4, 1, 8, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Async reset mid BB_WAIT, then a clean job from k=1.
    run_job(mk_job(2, 0, 3, 3, 6, 8, 0, 3, 0, 4), 3, 0, 4, 1'b0, 1'b1);
    tick();
    run_job(tbl[0], 3, 0, 4, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      rj = mk_job(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                  int'($urandom_range(1, 3)), int'($urandom_range(0, 11)),
                  int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                  int'($urandom_range(0, 11)), 0, 0, 0);
      run_job(rj, model_iter(rj), model_err(rj), model_k(model_iter(rj) - 1), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
